// File: rtl/intc_irq_responder.sv
// ---------------------------------------------------------------------------
// intc_irq_responder
//
// Processor-side responder for a level-sensitive interrupt controller.
// The responder captures the vector address and acknowledges the controller
// with a one-cycle "taken" code. It then waits for the controller to drop irq,
// bounded by a timeout. Next it offers the vector to a service engine with a
// valid/ready handshake and waits for the routine to finish. Finally it sends
// a one-cycle "return" code and counts the completed service.
//
// Ports
//   processor_clk      in   1   clock, all state on the rising edge
//   processor_rst      in   1   synchronous active-high reset
//   irq                in   1   level interrupt request
//   interrupt_address  in  32   vector address, valid while irq=1
//   processor_ack      out  2   00 idle, 01 taken, 10 return
//   enable             in   1   1 = accept new interrupts
//   vec_valid          out  1   vector offered to the service engine
//   vec_addr           out 32   captured vector address
//   vec_ready          in   1   service engine accepts the vector
//   svc_done           in   1   single-cycle pulse, service routine complete
//   busy               out  1   1 whenever the FSM is not idle
//   svc_count          out 16   completed services, saturating
//   timeout_err        out  1   sticky, irq failed to drop after acknowledge
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed for irq to drop after the acknowledge
//                   (2..65535)
//   SVC_COUNT_INIT  value that reset loads into svc_count. Keep the default
//                   of 0 in normal use. A nonzero value presets the counter,
//                   for example to reach the saturation point quickly.
// ---------------------------------------------------------------------------
module intc_irq_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [15:0] SVC_COUNT_INIT = 16'h0000
) (
    input  logic        processor_clk,
    input  logic        processor_rst,
    input  logic        irq,
    input  logic [31:0] interrupt_address,
    output logic [1:0]  processor_ack,
    input  logic        enable,
    output logic        vec_valid,
    output logic [31:0] vec_addr,
    input  logic        vec_ready,
    input  logic        svc_done,
    output logic        busy,
    output logic [15:0] svc_count,
    output logic        timeout_err
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ACK_IDLE  = 2'b00;
    localparam logic [1:0] ACK_TAKEN = 2'b01;
    localparam logic [1:0] ACK_RET   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACK      = 3'd1,
        S_WAIT_LOW = 3'd2,
        S_DISPATCH = 3'd3,
        S_SERVICE  = 3'd4,
        S_RETURN   = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] timer;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    always_ff @(posedge processor_clk) begin
        if (processor_rst) begin
            // Abandons any transaction in flight. No return code is issued.
            state       <= S_IDLE;
            vec_addr    <= '0;
            timer       <= '0;
            svc_count   <= SVC_COUNT_INIT;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // enable only gates leaving IDLE. It has no effect once a
                    // transaction has started.
                    if (irq && enable) begin
                        vec_addr <= interrupt_address;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    timer <= '0;
                    state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // timer holds the number of earlier WAIT_LOW cycles that
                    // had irq high. The timeout fires on the TIMEOUT_CYCLES-th
                    // cycle if irq is still high.
                    if (!irq) begin
                        state <= S_DISPATCH;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_DISPATCH;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_DISPATCH: begin
                    if (vec_ready) begin
                        state <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (svc_done) begin
                        state <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    svc_count <= sat_inc(svc_count);
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded directly from the state register.
    always_comb begin
        processor_ack = ACK_IDLE;
        if (state == S_ACK) begin
            processor_ack = ACK_TAKEN;
        end else if (state == S_RETURN) begin
            processor_ack = ACK_RET;
        end
    end

    assign vec_valid = (state == S_DISPATCH);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_intc_irq_responder.sv
module tb_intc_irq_responder;

    localparam int T = 64;

    localparam int PH_ACK  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_DISP = 3;
    localparam int PH_SVC  = 4;
    localparam int PH_RET  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq;
    logic [31:0] interrupt_address;
    logic        enable;
    logic        vec_ready;
    logic        svc_done;

    logic [1:0]  processor_ack;
    logic        vec_valid;
    logic [31:0] vec_addr;
    logic        busy;
    logic [15:0] svc_count;
    logic        timeout_err;

    logic [1:0]  sat_ack;
    logic        sat_vec_valid;
    logic [31:0] sat_vec_addr;
    logic        sat_busy;
    logic [15:0] sat_svc_count;
    logic        sat_timeout_err;

    int checks = 0;
    int failures = 0;

    // Reference state: completed services, sticky error, last captured vector.
    int          exp_count;
    logic        exp_err;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    intc_irq_responder #(.TIMEOUT_CYCLES(T)) dut (
        .processor_clk     (clk),
        .processor_rst     (rst),
        .irq               (irq),
        .interrupt_address (interrupt_address),
        .processor_ack     (processor_ack),
        .enable            (enable),
        .vec_valid         (vec_valid),
        .vec_addr          (vec_addr),
        .vec_ready         (vec_ready),
        .svc_done          (svc_done),
        .busy              (busy),
        .svc_count         (svc_count),
        .timeout_err       (timeout_err)
    );

    // Second instance with the counter preset near saturation.
    intc_irq_responder #(.TIMEOUT_CYCLES(T), .SVC_COUNT_INIT(16'hFFFE)) u_sat (
        .processor_clk     (clk),
        .processor_rst     (rst),
        .irq               (irq),
        .interrupt_address (interrupt_address),
        .processor_ack     (sat_ack),
        .enable            (enable),
        .vec_valid         (sat_vec_valid),
        .vec_addr          (sat_vec_addr),
        .vec_ready         (vec_ready),
        .svc_done          (svc_done),
        .busy              (sat_busy),
        .svc_count         (sat_svc_count),
        .timeout_err       (sat_timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq = 1'b0;
        enable = 1'b1;
        vec_ready = 1'b0;
        svc_done = 1'b0;
        interrupt_address = '0;
        step();
        step();
        rst = 1'b0;
        exp_count = 0;
        exp_err = 1'b0;
        exp_addr = '0;
    endtask

    // One full transaction starting from an IDLE cycle.
    //   h   : number of WAIT_LOW cycles during which irq is still high
    //   r   : cycles DISPATCH waits before vec_ready
    //   s   : cycles SERVICE waits before svc_done
    //   en0 : hold enable low for the whole transaction after capture
    //   b2b : keep irq high after WAIT_LOW so the next capture follows at once
    // The expected cycle-by-cycle phase sequence comes from plain arithmetic on
    // these delays.
    task automatic run_txn(input logic [31:0] addr, input int h, input int r,
                           input int s, input bit en0, input bit b2b);
        int   ph[$];
        bit   q_irq[$];
        bit   q_rdy[$];
        bit   q_done[$];
        int   wl;
        bit   to;
        logic [1:0] e_ack;
        logic e_err;

        checks++;
        if ({busy, processor_ack, vec_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_before_txn busy/ack/valid got=%b exp=0000",
                     {busy, processor_ack, vec_valid});
        end
        checks++;
        if (svc_count !== 16'(exp_count)) begin
            failures++;
            $display("FAIL idle_count got=%0d exp=%0d", svc_count, exp_count);
        end

        wl = (h < T) ? h + 1 : T;
        to = (h >= T);

        ph.push_back(PH_ACK); q_irq.push_back(1'b1);
        q_rdy.push_back(1'($urandom)); q_done.push_back(1'($urandom));
        for (int k = 1; k <= wl; k++) begin
            ph.push_back(PH_WAIT); q_irq.push_back(k <= h);
            q_rdy.push_back(1'($urandom)); q_done.push_back(1'($urandom));
        end
        for (int i = 0; i <= r; i++) begin
            ph.push_back(PH_DISP); q_irq.push_back(b2b);
            q_rdy.push_back(i == r); q_done.push_back(1'($urandom));
        end
        for (int i = 0; i <= s; i++) begin
            ph.push_back(PH_SVC); q_irq.push_back(b2b);
            q_rdy.push_back(1'($urandom)); q_done.push_back(i == s);
        end
        ph.push_back(PH_RET); q_irq.push_back(b2b);
        q_rdy.push_back(1'($urandom)); q_done.push_back(1'($urandom));

        // IDLE cycle: request with enable set.
        irq = 1'b1;
        enable = 1'b1;
        interrupt_address = addr;
        vec_ready = 1'($urandom);
        svc_done = 1'($urandom);
        step();
        exp_addr = addr;

        for (int j = 0; j < ph.size(); j++) begin
            e_ack = (ph[j] == PH_ACK) ? 2'b01 : (ph[j] == PH_RET) ? 2'b10 : 2'b00;
            e_err = (ph[j] >= PH_DISP) ? (exp_err | to) : exp_err;
            checks++;
            if ({processor_ack, vec_valid, busy} !== {e_ack, ph[j] == PH_DISP, 1'b1}) begin
                failures++;
                $display("FAIL txn_ctrl phase=%0d cyc=%0d ack/valid/busy got=%b exp=%b",
                         ph[j], j, {processor_ack, vec_valid, busy},
                         {e_ack, ph[j] == PH_DISP, 1'b1});
            end
            checks++;
            if (vec_addr !== exp_addr) begin
                failures++;
                $display("FAIL txn_vec_addr cyc=%0d got=%h exp=%h", j, vec_addr, exp_addr);
            end
            checks++;
            if (timeout_err !== e_err) begin
                failures++;
                $display("FAIL txn_timeout_err cyc=%0d got=%b exp=%b", j, timeout_err, e_err);
            end
            checks++;
            if (svc_count !== 16'(exp_count)) begin
                failures++;
                $display("FAIL txn_count cyc=%0d got=%0d exp=%0d", j, svc_count, exp_count);
            end
            irq = q_irq[j];
            vec_ready = q_rdy[j];
            svc_done = q_done[j];
            enable = en0 ? 1'b0 : 1'b1;
            interrupt_address = $urandom;
            step();
        end
        exp_err = exp_err | to;
        exp_count++;
        irq = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        irq = 1'b1;
        enable = 1'b1;
        vec_ready = 1'b1;
        svc_done = 1'b1;
        interrupt_address = 32'hDEAD_BEEF;
        step();
        step();
        step();
        checks++;
        if ({processor_ack, vec_valid, busy, timeout_err} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl ack/valid/busy/err got=%b exp=00000",
                     {processor_ack, vec_valid, busy, timeout_err});
        end
        checks++;
        if (vec_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_vec_addr got=%h exp=00000000", vec_addr);
        end
        checks++;
        if (svc_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", svc_count);
        end
        do_reset();
    endtask

    task automatic test_basic();
        run_txn(32'h0000_1040, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if ({busy, processor_ack} !== 3'b000 || svc_count !== 16'd1 || vec_addr !== 32'h0000_1040) begin
            failures++;
            $display("FAIL basic_done busy=%b ack=%b count=%0d addr=%h exp busy=0 ack=00 count=1 addr=00001040",
                     busy, processor_ack, svc_count, vec_addr);
        end
    endtask

    task automatic test_timeout();
        run_txn($urandom, T - 1, 0, 0, 1'b0, 1'b0);
        run_txn($urandom, T + 5, 1, 1, 1'b0, 1'b0);
        run_txn($urandom, T + 20, 0, 2, 1'b0, 1'b0);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
        end
    endtask

    task automatic test_backpressure();
        run_txn(32'hA5A5_0F00, 2, 10, 3, 1'b0, 1'b0);
    endtask

    task automatic test_enable();
        irq = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            interrupt_address = $urandom;
            vec_ready = 1'($urandom);
            svc_done = 1'($urandom);
            step();
            checks++;
            if ({busy, processor_ack, vec_valid} !== 4'b0000 || vec_addr !== exp_addr) begin
                failures++;
                $display("FAIL enable_block cyc=%0d busy/ack/valid=%b addr=%h exp=0000 addr=%h",
                         i, {busy, processor_ack, vec_valid}, vec_addr, exp_addr);
            end
        end
        irq = 1'b0;
        enable = 1'b1;
        step();
        run_txn(32'h0000_2200, 1, 2, 4, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        irq = 1'b1;
        enable = 1'b1;
        interrupt_address = 32'h0000_3300;
        step();
        irq = 1'b0;
        step();
        vec_ready = 1'b1;
        step();
        step();
        vec_ready = 1'b0;
        checks++;
        if ({busy, processor_ack, vec_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_in_service busy/ack/valid got=%b exp=1000",
                     {busy, processor_ack, vec_valid});
        end
        rst = 1'b1;
        svc_done = 1'b1;
        step();
        rst = 1'b0;
        svc_done = 1'b0;
        exp_count = 0;
        exp_err = 1'b0;
        exp_addr = '0;
        checks++;
        if ({busy, processor_ack, vec_valid, timeout_err} !== 5'b00000 ||
            svc_count !== 16'h0 || vec_addr !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset busy/ack/valid/err=%b count=%0d addr=%h exp=00000 0 0",
                     {busy, processor_ack, vec_valid, timeout_err}, svc_count, vec_addr);
        end
        for (int i = 0; i < 10; i++) begin
            svc_done = 1'($urandom);
            vec_ready = 1'($urandom);
            step();
            checks++;
            if (processor_ack !== 2'b00 || busy !== 1'b0 || svc_count !== 16'h0) begin
                failures++;
                $display("FAIL mid_after cyc=%0d ack=%b busy=%b count=%0d exp ack=00 busy=0 count=0",
                         i, processor_ack, busy, svc_count);
            end
        end
        svc_done = 1'b0;
        vec_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        checks++;
        if (sat_svc_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preset got=%h exp=fffe", sat_svc_count);
        end
        run_txn($urandom, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (sat_svc_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach got=%h exp=ffff", sat_svc_count);
        end
        run_txn($urandom, 1, 1, 0, 1'b1, 1'b0);
        checks++;
        if (sat_svc_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h exp=ffff", sat_svc_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            run_txn($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end
        step();
        checks++;
        if (svc_count !== 16'd30 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_total count=%0d busy=%b exp count=30 busy=0", svc_count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intc_irq_responder.md
INTC_IRQ_RESPONDER -- requirements
Module: intc_irq_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, cycles allowed for irq to drop after acknowledge; legal range 2..65535.
REQ-002 processor_clk  input  1  sole clock; all state on rising edge.
REQ-003 processor_rst  input  1  reset, synchronous, active-high.
REQ-004 irq  input  1  level interrupt request from the interrupt controller.
REQ-005 interrupt_address  input  32  vector address from the interrupt controller, valid while irq=1.
REQ-006 processor_ack  output  2  acknowledge code to the controller: 00 idle, 01 taken, 10 return; 11 never driven.
REQ-007 enable  input  1  1 = accept new interrupts.
REQ-008 vec_valid  output  1  vector offered to the service engine.
REQ-009 vec_addr  output  32  captured vector address.
REQ-010 vec_ready  input  1  service engine accepts vector.
REQ-011 svc_done  input  1  single-cycle pulse, service routine complete.
REQ-012 busy  output  1  1 whenever state is not IDLE.
REQ-013 svc_count  output  16  count of completed services.
REQ-014 timeout_err  output  1  sticky flag, irq failed to drop after acknowledge.

Function
REQ-015 FSM states SHALL be IDLE, ACK, WAIT_LOW, DISPATCH, SERVICE, RETURN; outputs decoded from registered state (Moore), except counters/flags which are registers.
REQ-016 IDLE: irq=1 and enable=1 sampled at edge -> capture interrupt_address into vec_addr, go ACK; otherwise stay.
REQ-017 ACK: processor_ack=01 for exactly one cycle, timer cleared, unconditional -> WAIT_LOW.
REQ-018 WAIT_LOW: irq=0 -> DISPATCH; timer increments each cycle irq=1; when timer reaches TIMEOUT_CYCLES-1 with irq=1 -> set timeout_err, go DISPATCH.
REQ-019 DISPATCH: vec_valid=1, vec_addr held stable; vec_valid&vec_ready at edge -> SERVICE; vec_valid SHALL NOT drop before acceptance.
REQ-020 SERVICE: svc_done=1 -> RETURN; otherwise wait indefinitely.
REQ-021 RETURN: processor_ack=10 for exactly one cycle; svc_count increments by 1, saturating at 0xFFFF; unconditional -> IDLE.
REQ-022 processor_ack SHALL be 00 in every state other than ACK and RETURN.
REQ-023 Latency: irq=1 sampled in IDLE at edge N -> processor_ack=01 during cycle N+1; minimum full transaction (irq low at once, vec_ready=1, svc_done next cycle) returns to IDLE 5 cycles after capture.
REQ-024 vec_addr SHALL change only on IDLE->ACK capture; interrupt_address changes afterwards are ignored.
REQ-025 enable=0 only blocks IDLE exit; an in-progress transaction completes normally.
REQ-026 svc_done in any state other than SERVICE SHALL be ignored; vec_ready outside DISPATCH ignored.
REQ-027 irq still high on returning to IDLE (new interrupt) -> new capture next edge, back-to-back allowed with one IDLE cycle.
REQ-028 timeout_err stays 1 until reset; further timeouts have no additional effect.

Reset
REQ-029 processor_rst=1 at an edge SHALL force IDLE from any state, mid-transaction included, with no RETURN code issued.
REQ-030 Reset values: processor_ack=00, vec_valid=0, vec_addr=0, busy=0, svc_count=0, timeout_err=0, timer=0.

Verification
REQ-031 irq=1, addr=0x0000_1040, enable=1, irq drops after ack, vec_ready=1, svc_done one cycle later -> ack 01 at N+1, vec_addr=0x1040, ack 10 once, svc_count=1.
REQ-032 irq held high 64+ cycles after ack (TIMEOUT_CYCLES=64) -> timeout_err=1 at 64th WAIT_LOW cycle, vec_valid=1 next cycle, flag persists through RETURN.
REQ-033 vec_ready=0 for 10 cycles in DISPATCH while interrupt_address toggles -> vec_valid and vec_addr stable all 10 cycles, accepted on 11th.
REQ-034 processor_rst pulsed during SERVICE -> next cycle busy=0, processor_ack=00, svc_count=0, no 10 code ever seen.
REQ-035 enable=0 with irq=1 -> no ack, busy=0; enable cleared during SERVICE -> transaction completes, svc_count increments; svc_count preset path to 0xFFFF -> stays 0xFFFF after another service.
